// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter generator: next-PC select
// encoding and the sequential instruction step.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_INC    = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JALR   = 2'd2,
        PC_RET    = 2'd3
    } pc_src_e;

    localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push when full overwrites the oldest
// entry; a simultaneous push and pop replaces the top in place.
module pc_ras #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic             empty,
    output logic             full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_ptr;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    w_top_idx;
    logic             w_pop;
    logic [PW-1:0]    w_wr_idx;

    assign w_top_idx = r_ptr - 1'b1;
    assign empty     = (r_cnt == '0);
    assign full      = (r_cnt == CW'(DEPTH));
    assign top       = r_mem[w_top_idx];
    assign w_pop     = pop && !empty;
    // Push+pop writes over the current top instead of the next free slot.
    assign w_wr_idx  = w_pop ? w_top_idx : r_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
            r_cnt <= '0;
        end else if (push && w_pop) begin
            r_ptr <= r_ptr;
            r_cnt <= r_cnt;
        end else if (push) begin
            r_ptr <= r_ptr + 1'b1;
            r_cnt <= full ? r_cnt : r_cnt + 1'b1;
        end else if (w_pop) begin
            r_ptr <= w_top_idx;
            r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: next-PC target mux, word-alignment check and
// the PC register, with call/return prediction through pc_ras.
module pc_gen
    import pc_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic [1:0]            pc_src,
    input  logic [DATA_WIDTH-1:0] imm_op,
    input  logic [DATA_WIDTH-1:0] rs1_val,
    input  logic                  ras_push,
    input  logic                  trap,
    input  logic [DATA_WIDTH-1:0] trap_vec,
    output logic [DATA_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] pc_plus4,
    output logic                  misaligned,
    output logic                  ras_empty,
    output logic                  ras_full
);

    logic [DATA_WIDTH-1:0] r_pc;
    logic                  r_misaligned;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic [DATA_WIDTH-1:0] w_jalr_sum;
    logic [DATA_WIDTH-1:0] w_jalr_tgt;
    logic [DATA_WIDTH-1:0] w_ras_top;
    logic [DATA_WIDTH-1:0] w_target;
    logic                  w_use_ras;
    logic                  w_accept;
    logic                  w_aligned;
    logic                  w_commit;

    assign w_pc_plus4 = r_pc + DATA_WIDTH'(PC_STEP);
    assign w_jalr_sum = rs1_val + imm_op;
    assign w_jalr_tgt = {w_jalr_sum[DATA_WIDTH-1:1], 1'b0};
    // RET with an empty stack falls back to the JALR target, so stale
    // storage is never selected.
    assign w_use_ras  = (pc_src_e'(pc_src) == PC_RET) && !ras_empty;

    always_comb begin
        w_target = w_pc_plus4;
        case (pc_src_e'(pc_src))
            PC_INC:    w_target = w_pc_plus4;
            PC_BRANCH: w_target = r_pc + imm_op;
            PC_JALR:   w_target = w_jalr_tgt;
            PC_RET:    w_target = w_use_ras ? w_ras_top : w_jalr_tgt;
            default:   w_target = w_pc_plus4;
        endcase
    end

    assign w_accept  = !trap && !stall;
    assign w_aligned = (w_target[1:0] == 2'b00);
    assign w_commit  = w_accept && w_aligned;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc         <= RESET_VECTOR;
            r_misaligned <= 1'b0;
        end else if (trap) begin
            r_pc         <= trap_vec;
            r_misaligned <= 1'b0;
        end else if (stall) begin
            r_misaligned <= 1'b0;
        end else if (w_aligned) begin
            r_pc         <= w_target;
            r_misaligned <= 1'b0;
        end else begin
            r_misaligned <= 1'b1;
        end
    end

    pc_ras #(
        .DEPTH (RAS_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (w_commit && ras_push),
        .pop       (w_commit && w_use_ras),
        .push_data (w_pc_plus4),
        .top       (w_ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign misaligned = r_misaligned;

endmodule
